// File: rtl/pattern_tx.sv
// Parallel-in, serial-out pattern transmitter.
// A pattern and length are captured by a load handshake in IDLE and then
// emitted MSB-first, one bit per clock, with a valid qualifier. Supports
// one-shot and continuous-loop modes plus a synchronous abort. Every output
// is registered, so no input reaches an output combinationally.
module pattern_tx #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             loop,
  input  logic             abort,
  output logic             w_out,
  output logic             w_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // The held pattern is zero-padded to 2^LEN_W bits so that any LEN_W-bit
  // counter value is a legal index without a width mismatch.
  localparam int PadW = 1 << LEN_W;
  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] One    = LEN_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PadW-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              loop_q, loop_d;
  logic              w_out_q, w_out_d;
  logic              w_valid_q, w_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [PadW-1:0]   pattern_ext;
  logic              len_ok;

  assign pattern_ext = {{(PadW-WIDTH){1'b0}}, pattern};
  assign len_ok      = (len != '0) && (len <= MaxLen);

  // Next-state and next-output decode; outputs default to the idle values.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    loop_d    = loop_q;
    w_out_d   = 1'b0;
    w_valid_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (load && !abort) begin
          if (len_ok) begin
            pat_d     = pattern_ext;
            len_d     = len;
            loop_d    = loop;
            cnt_d     = len - One;
            w_out_d   = pattern_ext[len - One];
            w_valid_d = 1'b1;
            busy_d    = 1'b1;
            state_d   = SHIFT;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          if (loop_q) begin
            cnt_d     = len_q - One;
            w_out_d   = pat_q[len_q - One];
            w_valid_d = 1'b1;
            busy_d    = 1'b1;
          end else begin
            busy_d  = 1'b1;
            done_d  = 1'b1;
            state_d = FIN;
          end
        end else begin
          cnt_d     = cnt_q - One;
          w_out_d   = pat_q[cnt_q - One];
          w_valid_d = 1'b1;
          busy_d    = 1'b1;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pattern store and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      loop_q    <= 1'b0;
      w_out_q   <= 1'b0;
      w_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      loop_q    <= loop_d;
      w_out_q   <= w_out_d;
      w_valid_q <= w_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign w_out   = w_out_q;
  assign w_valid = w_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx. Expected output vectors come from a
// cycle-indexed model of the transmitted stream: cycle k after the load edge
// carries pattern bit (len-1 - (k-1) mod len), then one done cycle, then idle.
module tb_pattern_tx;
  localparam int WIDTH = 8;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] pattern = '0;
  logic [LEN_W-1:0] len = '0;
  logic             loop = 1'b0;
  logic             abort = 1'b0;
  logic             w_out, w_valid, busy, done, err;
  logic [4:0]       obs;

  int checks = 0;
  int failures = 0;

  assign obs = {w_out, w_valid, busy, done, err};

  always #5 clk = ~clk;

  pattern_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .load(load), .pattern(pattern), .len(len),
    .loop(loop), .abort(abort), .w_out(w_out), .w_valid(w_valid),
    .busy(busy), .done(done), .err(err)
  );

  // Expected {w_out,w_valid,busy,done,err} k cycles after an accepted load.
  // abort_k is the edge at which abort is sampled (0 = never).
  function automatic logic [4:0] model(input logic [7:0] p, input int n,
                                       input bit lp, input int k, input int abort_k);
    logic [7:0] pv;
    int idx;
    pv = p;
    if (abort_k > 0 && k >= abort_k) return 5'b00000;
    if (k >= 1 && (lp || k <= n)) begin
      idx = n - 1 - ((k - 1) % n);
      return {pv[idx], 4'b1100};
    end
    if (!lp && k == n + 1) return 5'b00110;
    return 5'b00000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; load = 1'b1; pattern = 8'hB2; len = 4'd8; loop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== 5'b00000) begin
        failures++;
        $display("[TB] FAIL reset_held cyc=%0d got=%b exp=%b", i, obs, 5'b00000);
      end
    end
    rst = 1'b1; load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs !== 5'b00000) begin
        failures++;
        $display("[TB] FAIL reset_release cyc=%0d got=%b exp=%b", i, obs, 5'b00000);
      end
    end
  endtask

  task automatic test_one_shot();
    logic [7:0] p;
    logic [4:0] e;
    p = 8'b1011_0010;
    load = 1'b1; pattern = p; len = 4'd8; loop = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      step();
      e = model(p, 8, 1'b0, k, 0);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("[TB] FAIL one_shot k=%0d got=%b exp=%b", k, obs, e);
      end
      load = 1'b0;
      if (k < 8) begin
        pattern = 8'($urandom); len = 4'($urandom); loop = 1'($urandom);
      end else begin
        loop = 1'b0;
      end
    end
  endtask

  task automatic test_loop_abort();
    logic [7:0] p;
    logic [4:0] e;
    p = 8'hF5;
    load = 1'b1; pattern = p; len = 4'd3; loop = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      e = model(p, 3, 1'b1, k, 8);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("[TB] FAIL loop_abort k=%0d got=%b exp=%b", k, obs, e);
      end
      load = 1'b0;
      abort = (k + 1 == 8);
    end
    abort = 1'b0;
    p = 8'($urandom);
    load = 1'b1; pattern = p; len = 4'd1; loop = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      e = model(p, 1, 1'b1, k, 6);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("[TB] FAIL loop_len1 k=%0d got=%b exp=%b", k, obs, e);
      end
      load = 1'b0;
      abort = (k + 1 == 6);
    end
    abort = 1'b0; loop = 1'b0;
  endtask

  task automatic test_reject();
    int bad [3] = '{0, 9, 15};
    foreach (bad[i]) begin
      load = 1'b1; len = 4'(bad[i]); pattern = 8'($urandom); loop = 1'($urandom);
      step();
      load = 1'b0;
      checks++;
      if (obs !== 5'b00001) begin
        failures++;
        $display("[TB] FAIL reject_err len=%0d got=%b exp=%b", bad[i], obs, 5'b00001);
      end
      step();
      checks++;
      if (obs !== 5'b00000) begin
        failures++;
        $display("[TB] FAIL reject_after len=%0d got=%b exp=%b", bad[i], obs, 5'b00000);
      end
    end
    loop = 1'b0;
  endtask

  task automatic test_collisions();
    logic [7:0] p;
    logic [4:0] e;
    load = 1'b1; abort = 1'b1; len = 4'd5; pattern = 8'hFF; loop = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      step();
      load = 1'b0; abort = 1'b0;
      checks++;
      if (obs !== 5'b00000) begin
        failures++;
        $display("[TB] FAIL load_abort_idle k=%0d got=%b exp=%b", k, obs, 5'b00000);
      end
    end
    p = 8'hA7;
    load = 1'b1; pattern = p; len = 4'd8; loop = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      step();
      e = model(p, 8, 1'b0, k, 0);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("[TB] FAIL load_in_shift k=%0d got=%b exp=%b", k, obs, e);
      end
      load = (k == 2 || k == 3);
      if (load) begin
        pattern = 8'h00; len = 4'd5; loop = 1'b1;
      end else begin
        loop = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] p1, p2;
    int n1, n2;
    logic [4:0] e;
    p1 = 8'($urandom); n1 = $urandom_range(2, 8);
    p2 = 8'($urandom); n2 = $urandom_range(2, 8);
    load = 1'b1; pattern = p1; len = 4'(n1); loop = 1'b0;
    for (int k = 1; k <= n1 + 2; k++) begin
      step();
      e = model(p1, n1, 1'b0, k, 0);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("[TB] FAIL b2b_first k=%0d got=%b exp=%b", k, obs, e);
      end
      load = 1'b0;
      if (k == n1 + 1) begin
        load = 1'b1; pattern = ~p2; len = 4'd1; loop = 1'b1;
      end else if (k == n1 + 2) begin
        load = 1'b1; pattern = p2; len = 4'(n2); loop = 1'b0;
      end
    end
    for (int k = 1; k <= n2 + 2; k++) begin
      step();
      e = model(p2, n2, 1'b0, k, 0);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("[TB] FAIL b2b_second k=%0d got=%b exp=%b", k, obs, e);
      end
      load = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] p;
    logic [4:0] e;
    p = 8'($urandom);
    load = 1'b1; pattern = p; len = 4'd8; loop = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      e = model(p, 8, 1'b0, k, 0);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("[TB] FAIL async_pre k=%0d got=%b exp=%b", k, obs, e);
      end
      load = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs !== 5'b00000) begin
      failures++;
      $display("[TB] FAIL async_immediate got=%b exp=%b", obs, 5'b00000);
    end
    step();
    #2 rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (obs !== 5'b00000) begin
        failures++;
        $display("[TB] FAIL async_no_done k=%0d got=%b exp=%b", k, obs, 5'b00000);
      end
    end
    p = 8'($urandom);
    load = 1'b1; pattern = p; len = 4'd8; loop = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      step();
      e = model(p, 8, 1'b0, k, 0);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("[TB] FAIL async_after k=%0d got=%b exp=%b", k, obs, e);
      end
      load = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [7:0] p;
    logic [4:0] e;
    int n, ak, kmax;
    bit lp;
    for (int it = 0; it < 30; it++) begin
      p  = 8'($urandom);
      n  = $urandom_range(1, 8);
      lp = 1'($urandom_range(0, 1));
      if (lp) ak = $urandom_range(n + 1, 3 * n + 2);
      else    ak = ($urandom_range(0, 2) == 0) ? $urandom_range(2, n + 2) : 0;
      kmax = lp ? ak + 1 : n + 3;
      load = 1'b1; pattern = p; len = 4'(n); loop = lp; abort = 1'b0;
      for (int k = 1; k <= kmax; k++) begin
        step();
        e = model(p, n, lp, k, ak);
        checks++;
        if (obs !== e) begin
          failures++;
          $display("[TB] FAIL random it=%0d k=%0d got=%b exp=%b", it, k, obs, e);
        end
        load = 1'b0;
        pattern = 8'($urandom); len = 4'($urandom); loop = 1'($urandom);
        abort = (k + 1 == ak);
      end
      abort = 1'b0; loop = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_one_shot();
    test_loop_abort();
    test_reject();
    test_collisions();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
